can_tx_scheduler: RTL
=====================

CAN_TX_SCHEDULER -- requirements
Module: can_tx_scheduler

Interface
REQ-001 Parameter N_SLOTS, default 4: number of transmit mailboxes.
REQ-002 Parameter DW, default 108: frame payload width presented to the CAN controller DIN.
REQ-003 Parameter IDW, default 11: identifier width, held in bits [DW-1:DW-IDW] of each mailbox.
REQ-004 Parameter TIMEOUT, default 100000: GCLK cycles allowed per wait state before abandoning an attempt.
REQ-005 GCLK  in  1  sole clock; all logic on posedge.
REQ-006 RES  in  1  reset, synchronous, active-high.
REQ-007 LOAD  in  N_SLOTS  per-slot load strobe, one cycle.
REQ-008 SLOT_DATA  in  N_SLOTS*DW  flattened mailbox data; slot k at [k*DW +: DW].
REQ-009 ABORT  in  N_SLOTS  per-slot cancel strobe.
REQ-010 CAN_TX_READY  in  1  controller idle flag (from can_controller tx_ready).
REQ-011 CAN_DIN  out  DW  frame data to controller.
REQ-012 CAN_TX_START  out  1  one-cycle start pulse to controller.
REQ-013 PEND  out  N_SLOTS  slot holds a frame awaiting or in transmission.
REQ-014 DONE  out  N_SLOTS  one-cycle pulse per completed slot.
REQ-015 ERR  out  1  one-cycle pulse on timeout.
REQ-016 BUSY  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states IDLE, ARB, START, WAIT_ACK, WAIT_DONE shall be implemented.
REQ-018 IDLE -> ARB when |PEND and CAN_TX_READY=1; otherwise stay.
REQ-019 ARB shall select the pending slot with numerically lowest ID, ties to lowest slot index, latch its index as SEL and its data onto CAN_DIN, then go to START.
REQ-020 START shall assert CAN_TX_START for exactly one cycle, clear the timeout counter, then go to WAIT_ACK.
REQ-021 WAIT_ACK -> WAIT_DONE when CAN_TX_READY=0.
REQ-022 WAIT_DONE -> IDLE when CAN_TX_READY=1, clearing PEND[SEL] and pulsing DONE[SEL] in that same cycle.
REQ-023 Timeout counter shall increment each cycle in WAIT_ACK/WAIT_DONE, reset on state entry; on reaching TIMEOUT-1 the FSM shall go to IDLE, pulse ERR, and leave PEND[SEL] set.
REQ-024 LOAD[k] on a slot not in flight shall store SLOT_DATA slot k and set PEND[k] next cycle.
REQ-025 LOAD[k] or ABORT[k] when k=SEL and state is START, WAIT_ACK or WAIT_DONE shall be ignored.
REQ-026 ABORT[k] on a slot not in flight shall clear PEND[k] next cycle; LOAD[k] and ABORT[k] together: LOAD wins.
REQ-027 Latency: LOAD at cycle n with FSM idle and CAN_TX_READY=1 -> PEND at n+1, ARB at n+2, CAN_TX_START at n+3.
REQ-028 CAN_DIN shall hold its latched value from ARB until the next ARB.
REQ-029 Multiple LOADs in one cycle shall all be accepted.

Reset
REQ-030 RES=1 at a GCLK edge shall force state IDLE, PEND=0, DONE=0, ERR=0, CAN_TX_START=0, BUSY=0, CAN_DIN=0, SEL=0, counter=0, mailbox contents=0.
REQ-031 Reset mid-transmission shall drop the in-flight frame without a DONE pulse.

Structure
REQ-032 State encoding and the ID-field slice constants shall live in shared package can_pkg.
REQ-033 Arbitration shall be a combinational sub-module can_id_arbiter (inputs PEND, IDs; output winner index, valid).
REQ-034 Estimated RTL size: 150-300 lines.

Verification
REQ-035 LOAD slot 2 with ID 0x123, CAN_TX_READY=1 -> CAN_TX_START at n+3, CAN_DIN = slot 2 data; ready low 5 cycles then high -> DONE[2] pulse, PEND[2]=0.
REQ-036 Slots 0,1,3 loaded same cycle, IDs 0x300, 0x050, 0x050 -> sent order slot 1, slot 3, slot 0.
REQ-037 CAN_TX_READY held high after start, TIMEOUT=16 -> ERR after 16 cycles in WAIT_ACK, PEND[SEL] stays 1, retry follows.
REQ-038 ABORT slot 0 while slot 1 in flight -> PEND[0]=0 next cycle; ABORT slot 1 ignored, DONE[1] still pulses.
REQ-039 RES asserted in WAIT_DONE -> next cycle all outputs 0, no DONE pulse.
REQ-040 LOAD and ABORT on idle slot 2 same cycle -> PEND[2]=1.

Source files
------------

// File: rtl/can_pkg.sv
// Shared definitions for the CAN transmit scheduler: FSM encoding and
// frame layout constants used to locate the identifier field.
package can_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARB       = 3'd1,
        START     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    localparam int DEF_DW  = 108;
    localparam int DEF_IDW = 11;

    // The identifier occupies the top IDW bits of a frame; this gives its LSB.
    function automatic int id_lsb(input int dw, input int idw);
        return dw - idw;
    endfunction

endpackage

// File: rtl/can_id_arbiter.sv
// Combinational priority picker: among pending mailboxes, the lowest
// identifier wins, with equal identifiers resolved toward the lowest slot.
module can_id_arbiter #(
    parameter int N_SLOTS = 4,
    parameter int IDW     = 11,
    parameter int SW      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic [N_SLOTS-1:0]     pend,
    input  logic [N_SLOTS*IDW-1:0] ids,
    output logic [SW-1:0]          winner,
    output logic                   valid
);

    logic [IDW-1:0] best_id;

    // Strict less-than keeps the earlier (lower-index) slot on a tie.
    always_comb begin
        winner  = '0;
        valid   = 1'b0;
        best_id = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (pend[k] && (!valid || (ids[k*IDW +: IDW] < best_id))) begin
                valid   = 1'b1;
                winner  = SW'(k);
                best_id = ids[k*IDW +: IDW];
            end
        end
    end

endmodule

// File: rtl/can_tx_scheduler.sv
// Transmit mailbox scheduler: holds N_SLOTS frames, picks the highest
// priority pending frame and hands it to the CAN controller, watching the
// controller's ready flag for start/finish and abandoning stalled attempts.
module can_tx_scheduler
    import can_pkg::*;
#(
    parameter int N_SLOTS = 4,
    parameter int DW      = DEF_DW,
    parameter int IDW     = DEF_IDW,
    parameter int TIMEOUT = 100000
) (
    input  logic                    GCLK,
    input  logic                    RES,
    input  logic [N_SLOTS-1:0]      LOAD,
    input  logic [N_SLOTS*DW-1:0]   SLOT_DATA,
    input  logic [N_SLOTS-1:0]      ABORT,
    input  logic                    CAN_TX_READY,
    output logic [DW-1:0]           CAN_DIN,
    output logic                    CAN_TX_START,
    output logic [N_SLOTS-1:0]      PEND,
    output logic [N_SLOTS-1:0]      DONE,
    output logic                    ERR,
    output logic                    BUSY
);

    localparam int SW     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int CW     = $clog2(TIMEOUT + 1);
    localparam int ID_LSB = id_lsb(DW, IDW);

    state_t                 state;
    logic [SW-1:0]          sel;
    logic [CW-1:0]          tmo_cnt;
    logic [DW-1:0]          mbox [N_SLOTS];
    logic [N_SLOTS*IDW-1:0] ids;
    logic [N_SLOTS-1:0]     in_flight;
    logic [SW-1:0]          arb_winner;
    logic                   arb_valid;
    logic                   timeout_hit;

    assign BUSY        = (state != IDLE);
    assign timeout_hit = (tmo_cnt == CW'(TIMEOUT - 1));

    // Gather each mailbox's identifier field for the arbiter.
    always_comb begin
        ids = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            ids[k*IDW +: IDW] = mbox[k][ID_LSB +: IDW];
        end
    end

    // Mark the slot currently handed to the controller so host writes to it are ignored.
    always_comb begin
        in_flight = '0;
        if (state == START || state == WAIT_ACK || state == WAIT_DONE) begin
            in_flight[sel] = 1'b1;
        end
    end

    can_id_arbiter #(
        .N_SLOTS (N_SLOTS),
        .IDW     (IDW),
        .SW      (SW)
    ) u_arb (
        .pend   (PEND),
        .ids    (ids),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // Mailbox storage: capture host data on LOAD unless that slot is in flight.
    always_ff @(posedge GCLK) begin
        if (RES) begin
            for (int k = 0; k < N_SLOTS; k++) begin
                mbox[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_SLOTS; k++) begin
                if (LOAD[k] && !in_flight[k]) begin
                    mbox[k] <= SLOT_DATA[k*DW +: DW];
                end
            end
        end
    end

    // Pending flags plus the transmit FSM; completion clears the in-flight slot's flag.
    always_ff @(posedge GCLK) begin
        if (RES) begin
            state        <= IDLE;
            PEND         <= '0;
            DONE         <= '0;
            ERR          <= 1'b0;
            CAN_TX_START <= 1'b0;
            CAN_DIN      <= '0;
            sel          <= '0;
            tmo_cnt      <= '0;
        end else begin
            DONE         <= '0;
            ERR          <= 1'b0;
            CAN_TX_START <= 1'b0;
            for (int k = 0; k < N_SLOTS; k++) begin
                if (!in_flight[k]) begin
                    if (LOAD[k]) begin
                        PEND[k] <= 1'b1;
                    end else if (ABORT[k]) begin
                        PEND[k] <= 1'b0;
                    end
                end
            end
            case (state)
                IDLE: begin
                    if (|PEND && CAN_TX_READY) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (arb_valid) begin
                        sel          <= arb_winner;
                        CAN_DIN      <= mbox[arb_winner];
                        CAN_TX_START <= 1'b1;
                        state        <= START;
                    end else begin
                        state <= IDLE;
                    end
                end
                START: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!CAN_TX_READY) begin
                        tmo_cnt <= '0;
                        state   <= WAIT_DONE;
                    end else if (timeout_hit) begin
                        ERR   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (CAN_TX_READY) begin
                        PEND[sel] <= 1'b0;
                        DONE[sel] <= 1'b1;
                        state     <= IDLE;
                    end else if (timeout_hit) begin
                        ERR   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
